// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR MAC scheduler.
package fir_pkg;

    localparam int TAPS_DEF    = 32;
    localparam int FILTERS_DEF = 4;
    localparam int MAC_LAT_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FLUSH,
        BYP0,
        BYP1
    } sched_state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int unsigned lowest_set_idx(input logic [31:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = $unsigned(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// Control bundle between the FIR scheduler (master) and the packet-detect / ROM / RAM / MAC side (slave).
interface fir_mac_scheduler_if #(
    parameter int TAPS    = 32,
    parameter int FILTERS = 4,
    parameter int ADDR_W  = $clog2(TAPS),
    parameter int BANK_W  = $clog2(FILTERS)
);
    logic [FILTERS-1:0] modes;
    logic               start;
    logic               busy;
    logic               overrun;
    logic               sample_wr_en;
    logic [ADDR_W-1:0]  sample_wr_ptr;
    logic [ADDR_W-1:0]  sample_rd_addr;
    logic               ch_sel;
    logic [BANK_W-1:0]  coef_bank;
    logic [ADDR_W-1:0]  coef_addr;
    logic               mac_clr;
    logic               mac_en;
    logic               mac_last;
    logic               bypass;
    logic               out_valid;
    logic               out_ch;

    modport master (
        input  modes, start,
        output busy, overrun, sample_wr_en, sample_wr_ptr, sample_rd_addr, ch_sel,
               coef_bank, coef_addr, mac_clr, mac_en, mac_last, bypass, out_valid, out_ch
    );

    modport slave (
        output modes, start,
        input  busy, overrun, sample_wr_en, sample_wr_ptr, sample_rd_addr, ch_sel,
               coef_bank, coef_addr, mac_clr, mac_en, mac_last, bypass, out_valid, out_ch
    );
endinterface

// File: rtl/pulse_delay.sv
// Fixed DEPTH-cycle shift register for control strobes; latency DEPTH, no backpressure.
module pulse_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fir_mac_scheduler.sv
// Shares one MAC across all taps of both channels: LOAD, 2*TAPS RUN cycles, MAC_LAT FLUSH cycles.
// No backpressure: a start arriving while busy is dropped and flagged on overrun.
module fir_mac_scheduler
    import fir_pkg::*;
#(
    parameter int TAPS    = TAPS_DEF,
    parameter int FILTERS = FILTERS_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF,
    parameter int ADDR_W  = $clog2(TAPS)
) (
    input  logic               clk,
    input  logic               resetn,
    fir_mac_scheduler_if.master bus
);

    localparam int BANK_W  = $clog2(FILTERS);
    localparam int FLUSH_W = $clog2(MAC_LAT + 1);

    sched_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  tap_q, tap_d;
    logic [ADDR_W-1:0]  rd_q, rd_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic               ch_q, ch_d;
    logic [BANK_W-1:0]  bank_q, bank_d;
    logic [FLUSH_W-1:0] fl_q, fl_d;
    logic               mac_last_w;
    logic               dly_vld, dly_ch;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            tap_q    <= '0;
            rd_q     <= '0;
            wr_ptr_q <= '0;
            ch_q     <= 1'b0;
            bank_q   <= '0;
            fl_q     <= '0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            rd_q     <= rd_d;
            wr_ptr_q <= wr_ptr_d;
            ch_q     <= ch_d;
            bank_q   <= bank_d;
            fl_q     <= fl_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        ch_d     = ch_q;
        wr_ptr_d = wr_ptr_q;
        bank_d   = bank_q;
        fl_d     = fl_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = LOAD;
            LOAD: begin
                bank_d = BANK_W'(lowest_set_idx(32'(bus.modes)));
                tap_d  = '0;
                ch_d   = 1'b0;
                state_d = (bus.modes == '0) ? BYP0 : RUN;
            end
            RUN: begin
                // TAPS is a power of two, so the tap counter wraps to 0 by itself.
                tap_d = tap_q + ADDR_W'(1);
                if (tap_q == ADDR_W'(TAPS - 1)) begin
                    if (ch_q) begin
                        ch_d    = 1'b0;
                        fl_d    = '0;
                        state_d = FLUSH;
                    end else begin
                        ch_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                fl_d = fl_q + FLUSH_W'(1);
                if (fl_q == FLUSH_W'(MAC_LAT - 1)) begin
                    fl_d     = '0;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    state_d  = IDLE;
                end
            end
            BYP0: state_d = BYP1;
            BYP1: begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Read address is precomputed so it lands in the same cycle as mac_en.
        rd_d = (state_d == RUN) ? (wr_ptr_q - tap_d) : '0;
    end

    assign mac_last_w = (state_q == RUN) && (tap_q == ADDR_W'(TAPS - 1));

    pulse_delay #(
        .DEPTH (MAC_LAT),
        .WIDTH (2)
    ) u_result_dly (
        .clk    (clk),
        .resetn (resetn),
        .din    ({mac_last_w, mac_last_w & ch_q}),
        .dout   ({dly_vld, dly_ch})
    );

    assign bus.busy           = (state_q != IDLE);
    assign bus.overrun        = bus.start && (state_q != IDLE);
    assign bus.sample_wr_en   = (state_q == LOAD);
    assign bus.sample_wr_ptr  = wr_ptr_q;
    assign bus.sample_rd_addr = rd_q;
    assign bus.coef_addr      = tap_q;
    assign bus.ch_sel         = ch_q;
    assign bus.coef_bank      = bank_q;
    assign bus.mac_en         = (state_q == RUN);
    assign bus.mac_clr        = (state_q == RUN) && (tap_q == '0);
    assign bus.mac_last       = mac_last_w;
    assign bus.bypass         = (state_q == BYP0) || (state_q == BYP1);
    assign bus.out_valid      = dly_vld || (state_q == BYP0) || (state_q == BYP1);
    assign bus.out_ch         = dly_ch || (state_q == BYP1);

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler with TAPS=32, FILTERS=4, MAC_LAT=2.
module tb_fir_mac_scheduler;

    localparam int TAPS    = 32;
    localparam int FILTERS = 4;
    localparam int MAC_LAT = 2;

    // Flag bit positions: {busy, overrun, wr_en, mac_en, mac_clr, mac_last, out_valid, out_ch, bypass}
    localparam logic [8:0] BSY = 9'h100;
    localparam logic [8:0] OVR = 9'h080;
    localparam logic [8:0] WEN = 9'h040;
    localparam logic [8:0] MEN = 9'h020;
    localparam logic [8:0] CLR = 9'h010;
    localparam logic [8:0] LST = 9'h008;
    localparam logic [8:0] OV  = 9'h004;
    localparam logic [8:0] OCH = 9'h002;
    localparam logic [8:0] BYP = 9'h001;
    localparam logic [8:0] NON = 9'h000;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fir_mac_scheduler_if #(.TAPS(TAPS), .FILTERS(FILTERS)) bus ();

    fir_mac_scheduler #(
        .TAPS    (TAPS),
        .FILTERS (FILTERS),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    typedef struct {
        string      name;
        logic [3:0] modes;
        int         cyc;
        logic [8:0] fl;
        logic       ch;
        logic [4:0] rd;
        logic [4:0] coef;
        logic [1:0] bank;
        logic [4:0] wp;
    } vec_t;

    function automatic vec_t mk(string n, logic [3:0] m, int c, logic [8:0] f,
                                int ch, int rd, int coef, int bank, int wp);
        vec_t v;
        v.name = n; v.modes = m; v.cyc = c; v.fl = f;
        v.ch = 1'(ch); v.rd = 5'(rd); v.coef = 5'(coef); v.bank = 2'(bank); v.wp = 5'(wp);
        return v;
    endfunction

    function automatic logic [8:0] flags();
        return {bus.busy, bus.overrun, bus.sample_wr_en, bus.mac_en, bus.mac_clr,
                bus.mac_last, bus.out_valid, bus.out_ch, bus.bypass};
    endfunction

    function automatic logic [31:0] dpath();
        return {14'b0, bus.ch_sel, bus.sample_rd_addr, bus.coef_addr, bus.coef_bank, bus.sample_wr_ptr};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.modes = '0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    vec_t vt[18];

    initial begin
        vt[0]  = mk("rst_c0",     4'b0001,  0, NON,             0,  0,  0, 0, 0);
        vt[1]  = mk("load_c1",    4'b0001,  1, BSY|WEN,         0,  0,  0, 0, 0);
        vt[2]  = mk("tap0_c2",    4'b0001,  2, BSY|MEN|CLR,     0,  0,  0, 0, 0);
        vt[3]  = mk("tap1_c3",    4'b0001,  3, BSY|MEN,         0, 31,  1, 0, 0);
        vt[4]  = mk("last0_c33",  4'b0001, 33, BSY|MEN|LST,     0,  1, 31, 0, 0);
        vt[5]  = mk("clr1_c34",   4'b0001, 34, BSY|MEN|CLR,     1,  0,  0, 0, 0);
        vt[6]  = mk("ov0_c35",    4'b0001, 35, BSY|MEN|OV,      1, 31,  1, 0, 0);
        vt[7]  = mk("last1_c65",  4'b0001, 65, BSY|MEN|LST,     1,  1, 31, 0, 0);
        vt[8]  = mk("flush_c66",  4'b0001, 66, BSY,             0,  0,  0, 0, 0);
        vt[9]  = mk("ov1_c67",    4'b0001, 67, BSY|OV|OCH,      0,  0,  0, 0, 0);
        vt[10] = mk("idle_c68",   4'b0001, 68, NON,             0,  0,  0, 0, 1);
        vt[11] = mk("bank2_c2",   4'b0100,  2, BSY|MEN|CLR,     0,  0,  0, 2, 0);
        vt[12] = mk("bank1_c2",   4'b0110,  2, BSY|MEN|CLR,     0,  0,  0, 1, 0);
        vt[13] = mk("bank3_c3",   4'b1000,  3, BSY|MEN,         0, 31,  1, 3, 0);
        vt[14] = mk("byp_load",   4'b0000,  1, BSY|WEN,         0,  0,  0, 0, 0);
        vt[15] = mk("byp0_c2",    4'b0000,  2, BSY|OV|BYP,      0,  0,  0, 0, 0);
        vt[16] = mk("byp1_c3",    4'b0000,  3, BSY|OV|OCH|BYP,  0,  0,  0, 0, 0);
        vt[17] = mk("byp_idle",   4'b0000,  4, NON,             0,  0,  0, 0, 1);

        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.modes = '0;
        #1;
        check("reset_flags", 32'(flags()), 32'(NON));
        check("reset_dpath", dpath(), 32'h0);

        // Table: fresh reset, start at cycle 0, observe the chosen cycle.
        for (int i = 0; i < 18; i++) begin
            vec_t v;
            v = vt[i];
            do_reset();
            for (int c = 0; c <= v.cyc; c++) begin
                bus.modes = v.modes;
                bus.start = (c == 0);
                if (c < v.cyc) tick();
            end
            #1;
            check({v.name, "_flags"}, 32'(flags()), 32'(v.fl));
            check({v.name, "_dpath"}, dpath(), {14'b0, v.ch, v.rd, v.coef, v.bank, v.wp});
            bus.start = 1'b0;
        end

        // 33 back-to-back packets: write pointer walk and wrap, read address pattern.
        do_reset();
        for (int p = 0; p < 33; p++) begin
            bus.modes = 4'b0100;
            bus.start = 1'b1;
            #1;
            check($sformatf("b2b_idle_p%0d", p), 32'(bus.busy), 32'h0);
            check($sformatf("b2b_wrptr_p%0d", p), 32'(bus.sample_wr_ptr), 32'(p % TAPS));
            tick();
            bus.start = 1'b0;
            for (int c = 1; c < 68; c++) begin
                if (p == 32 && c >= 2 && c <= 65) begin
                    #1;
                    check($sformatf("b2b_rd_c%0d", c), 32'(bus.sample_rd_addr),
                          32'((TAPS - ((c - 2) % TAPS)) % TAPS));
                    if (c == 2) check("b2b_bank", 32'(bus.coef_bank), 32'd2);
                end
                tick();
            end
        end

        // Mode change mid-RUN does not disturb the latched bank.
        do_reset();
        bus.modes = 4'b0110;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        bus.modes = 4'b1000;
        #1;
        check("midrun_bank_c20", 32'(bus.coef_bank), 32'd1);
        tick();
        check("midrun_bank_c21", 32'(bus.coef_bank), 32'd1);
        for (int c = 21; c < 68; c++) tick();
        check("midrun_bank_c68", 32'(bus.coef_bank), 32'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("newpkt_bank", 32'(bus.coef_bank), 32'd3);

        // Overrun on a start arriving during RUN.
        begin
            int nvld;
            nvld = 0;
            do_reset();
            bus.modes = 4'b0001;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int c = 1; c < 10; c++) begin
                nvld += int'(bus.out_valid);
                tick();
            end
            bus.start = 1'b1;
            #1;
            check("ovr_c10", 32'(bus.overrun), 32'h1);
            tick();
            bus.start = 1'b0;
            #1;
            check("ovr_c11_clear", 32'(bus.overrun), 32'h0);
            for (int c = 11; c < 76; c++) begin
                nvld += int'(bus.out_valid);
                if (c == 68) check("ovr_busy_c68", 32'(bus.busy), 32'h0);
                tick();
            end
            check("ovr_valid_count", 32'(nvld), 32'd2);
        end

        // Reset asserted mid-RUN aborts the packet.
        begin
            int nvld;
            nvld = 0;
            do_reset();
            bus.modes = 4'b0100;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int c = 1; c < 68; c++) tick();
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int c = 1; c < 20; c++) tick();
            check("rstrun_pre_wrptr", 32'(bus.sample_wr_ptr), 32'd1);
            resetn = 1'b0;
            #1;
            check("rstrun_flags", 32'(flags()), 32'(NON));
            check("rstrun_dpath", dpath(), 32'h0);
            tick();
            tick();
            resetn = 1'b1;
            for (int c = 0; c < 70; c++) begin
                nvld += int'(bus.out_valid);
                tick();
            end
            check("rstrun_no_valid", 32'(nvld), 32'd0);
            bus.modes = 4'b0001;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int c = 1; c <= 68; c++) begin
                if (c == 33) check("post_rst_last_c33", 32'(flags()), 32'(BSY|MEN|LST));
                if (c == 35) check("post_rst_ov_c35",   32'(flags()), 32'(BSY|MEN|OV));
                if (c == 67) check("post_rst_ov_c67",   32'(flags()), 32'(BSY|OV|OCH));
                if (c == 68) check("post_rst_idle_c68", 32'(flags()), 32'(NON));
                if (c < 68) tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
Sequencer that time-multiplexes one shared multiply-accumulate unit across all taps of both audio channels in the FIR filter datapath. On each new stereo packet it writes the fresh samples into the circular delay line, then generates sample-read and coefficient addresses tap by tap, first for the left channel and then for the right. It also drives the MAC control strobes and signals per-channel result validity to the AXIS output stage. It sits between the AXIS slave packet-detect logic and the coefficient ROM, delay-line RAM and MAC.

Parameters:
TAPS, 32, filter length; must be a power of two.
FILTERS, 4, number of coefficient banks, one per mode switch.
MAC_LAT, 2, MAC pipeline latency in cycles, from the mac_en/mac_last cycle to the accumulator result.
ADDR_W, $clog2(TAPS), width of the tap and delay-line addresses.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
modes  in  FILTERS  filter select switches
start  in  1  pulse: both channel samples registered
busy  out  1  high from LOAD through FLUSH
overrun  out  1  one-cycle pulse when start arrives while busy
sample_wr_en  out  1  write both channel samples to the delay line at sample_wr_ptr
sample_wr_ptr  out  ADDR_W  slot holding the newest sample
sample_rd_addr  out  ADDR_W  delay-line read address
ch_sel  out  1  0 = left, 1 = right (read port and MAC)
coef_bank  out  $clog2(FILTERS)  coefficient bank latched for the packet
coef_addr  out  ADDR_W  coefficient index
mac_clr  out  1  clear the accumulator; coincident with tap 0
mac_en  out  1  accumulate this cycle
mac_last  out  1  final tap of the current channel
bypass  out  1  high when no filter is selected; datapath passes the sample through
out_valid  out  1  one-cycle pulse: result for out_ch is valid
out_ch  out  1  channel of the out_valid result

Behaviour:
- Reset (asynchronous, resetn=0):
  - State to IDLE; tap counter, sample_wr_ptr and coef_bank to 0.
  - Delay shift register cleared.
  - Every output 0.
  - Reset asserted mid-packet aborts the packet with no out_valid.
- States: IDLE, LOAD, RUN, FLUSH, BYP0, BYP1.
- IDLE: start=1 moves to LOAD at the next edge.
- LOAD (1 cycle):
  - sample_wr_en=1.
  - coef_bank := index of the lowest set bit of modes.
  - bypass latched := (modes==0).
  - Next state is BYP0 if bypass, else RUN with ch=0, tap=0.
- RUN (one tap per cycle):
  - sample_rd_addr = (sample_wr_ptr - tap) mod TAPS.
  - coef_addr = tap; mac_en=1.
  - mac_clr=1 when tap==0; mac_last=1 when tap==TAPS-1.
  - At tap TAPS-1 with ch=0: set ch=1, tap=0.
  - At tap TAPS-1 with ch=1: go to FLUSH.
- FLUSH: holds MAC_LAT cycles, then sample_wr_ptr := sample_wr_ptr+1 (wraps TAPS-1 to 0) and the FSM returns to IDLE.
- out_valid / out_ch: mac_last and ch delayed by exactly MAC_LAT cycles through a shift register.
- Timing, start sampled at edge t:
  - mac_last at cycles t+TAPS+1 and t+2*TAPS+1.
  - out_valid at cycles t+TAPS+1+MAC_LAT (ch 0) and t+2*TAPS+1+MAC_LAT (ch 1).
  - IDLE at cycle t+2*TAPS+2+MAC_LAT.
- Bypass path:
  - BYP0 drives out_valid=1, out_ch=0, bypass=1.
  - BYP1 drives out_valid=1, out_ch=1, bypass=1, and increments sample_wr_ptr.
  - Then IDLE. The delay line keeps recording so history stays continuous when a filter is re-enabled.
- start when state != IDLE: ignored; overrun pulses for that cycle.
- modes are sampled only in LOAD; changes mid-packet take effect on the next packet.
- Outputs not named for a state are 0 in that state.
- sample_rd_addr, coef_addr and ch_sel are registered, aligned with mac_en.

Decomposition:
- fir_pkg holds:
  - the state enum (sched_state_t);
  - the TAPS, MAC_LAT and FILTERS defaults;
  - a priority-encoder function, lowest_set_idx.
- One sub-module, pulse_delay (parameters DEPTH and WIDTH): shift register carrying {mac_last, ch} into {out_valid, out_ch}, reset to 0.

Test Plan:
- TAPS=32, MAC_LAT=2, modes=4'b0001, start at t=0 -> sample_wr_en at cycle 1, mac_clr at 2 and 34, mac_last at 33 and 65, out_valid ch0 at 35 and ch1 at 67, busy low at 68, coef_bank=0.
- Run 33 packets back-to-back with modes=4'b0100 -> coef_bank=2; on packet 32 sample_wr_ptr has wrapped to 0, and read addresses go 0,31,30,...,1 for each channel.
- modes=4'b0110 -> coef_bank=1; toggle modes to 4'b1000 mid-RUN -> coef_bank stays 1 until the next LOAD.
- modes=0, start -> no mac_en; out_valid with bypass=1 at cycle 2 (ch0) and cycle 3 (ch1); sample_wr_ptr increments by 1.
- start pulsed at cycle 10 of a running packet -> overrun=1 for exactly that cycle; the packet completes with exactly two out_valid pulses.
- resetn low at cycle 20 of RUN -> all outputs 0 immediately and sample_wr_ptr=0; no out_valid; the next start gives standard timing.
